// File: rtl/deserializer.sv
// Serial-to-parallel converter: collects WIDTH enabled bits into a word and
// presents it through a one-entry valid/ready holding register with overrun flag.
module deserializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                                     in_clock,
  input  logic                                     in_reset,
  input  logic                                     in_enable,
  input  logic                                     in_bit,
  input  logic                                     in_clear,
  input  logic                                     in_ready,
  output logic [WIDTH-1:0]                         out_data,
  output logic                                     out_valid,
  output logic                                     out_overrun,
  output logic [((WIDTH < 3) ? 1 : $clog2(WIDTH))-1:0] out_count
);

  localparam int CW = (WIDTH < 3) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    if (MSB_FIRST != 0) shifted = {shreg_q[WIDTH-2:0], in_bit};
    else                shifted = {in_bit, shreg_q[WIDTH-1:1]};
  end

  always_comb begin
    shreg_d   = shreg_q;
    data_d    = data_q;
    count_d   = count_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    // A drain on this edge frees the holding register; a completing word
    // below may refill it on the same edge.
    if (valid_q && in_ready) valid_d = 1'b0;

    if (in_clear) begin
      shreg_d   = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else if (in_enable) begin
      shreg_d = shifted;
      if (count_q == LAST) begin
        count_d = '0;
        if (!valid_q || in_ready) begin
          data_d  = shifted;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      shreg_q   <= '0;
      data_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_overrun = overrun_q;
  assign out_count   = count_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: an MSB-first and an LSB-first instance
// share stimulus; expected words are hand-computed constants.
module tb_deserializer;

  logic       in_clock;
  logic       in_reset;
  logic       in_enable;
  logic       in_bit;
  logic       in_clear;
  logic       in_ready;

  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid;
  logic       m_ovr, l_ovr;
  logic [2:0] m_count, l_count;

  int total;
  int bad;

  deserializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .in_clock(in_clock), .in_reset(in_reset), .in_enable(in_enable),
    .in_bit(in_bit), .in_clear(in_clear), .in_ready(in_ready),
    .out_data(m_data), .out_valid(m_valid), .out_overrun(m_ovr),
    .out_count(m_count)
  );

  deserializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .in_clock(in_clock), .in_reset(in_reset), .in_enable(in_enable),
    .in_bit(in_bit), .in_clear(in_clear), .in_ready(in_ready),
    .out_data(l_data), .out_valid(l_valid), .out_overrun(l_ovr),
    .out_count(l_count)
  );

  initial begin
    in_clock = 1'b0;
    forever #5 in_clock = ~in_clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, return 1 time unit after the next rising edge.
  task automatic step(input logic en, input logic b, input logic rdy, input logic clr);
    @(negedge in_clock);
    in_enable = en;
    in_bit    = b;
    in_ready  = rdy;
    in_clear  = clr;
    @(posedge in_clock);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy);
    for (int i = 0; i < 8; i++) step(1'b1, w[7-i], rdy, 1'b0);
  endtask

  initial begin
    logic [7:0] lsb_bits;
    total     = 0;
    bad       = 0;
    in_reset  = 1'b1;
    in_enable = 1'b0;
    in_bit    = 1'b0;
    in_clear  = 1'b0;
    in_ready  = 1'b0;
    repeat (2) @(posedge in_clock);
    #1;
    chk("rst_data",  32'(m_data),  32'h0);
    chk("rst_valid", 32'(m_valid), 32'h0);
    chk("rst_ovr",   32'(m_ovr),   32'h0);
    chk("rst_count", 32'(m_count), 32'h0);
    chk("rst_lsb_data", 32'(l_data), 32'h0);
    @(negedge in_clock);
    in_reset = 1'b0;

    // Basic word
    send_word(8'hAA, 1'b1);
    chk("basic_data",  32'(m_data),  32'hAA);
    chk("basic_valid", 32'(m_valid), 32'h1);
    chk("basic_count", 32'(m_count), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("basic_valid_drop", 32'(m_valid), 32'h0);

    // Gapped enable: 0,0,1 | gap x3 | 1,0,1,0,1
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("gap_count", 32'(m_count), 32'h3);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("gap_valid_early", 32'(m_valid), 32'h0);
    chk("gap_count7",      32'(m_count), 32'h7);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("gap_data",  32'(m_data),  32'h35);
    chk("gap_valid", 32'(m_valid), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("gap_valid_drop", 32'(m_valid), 32'h0);

    // Overrun, then drain on the completing edge of a third word
    send_word(8'hAA, 1'b0);
    chk("ovr_first_data", 32'(m_data),  32'hAA);
    chk("ovr_first_flag", 32'(m_ovr),   32'h0);
    send_word(8'h35, 1'b0);
    chk("ovr_keep_data",  32'(m_data),  32'hAA);
    chk("ovr_keep_valid", 32'(m_valid), 32'h1);
    chk("ovr_flag",       32'(m_ovr),   32'h1);
    chk("ovr_count",      32'(m_count), 32'h0);
    for (int i = 0; i < 7; i++) step(1'b1, (i >= 4), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("drain_valid", 32'(m_valid), 32'h1);
    chk("drain_data",  32'(m_data),  32'h0F);
    chk("drain_ovr",   32'(m_ovr),   32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_ovr",   32'(m_ovr),   32'h0);
    chk("clr_valid", 32'(m_valid), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_drain", 32'(m_valid), 32'h0);

    // Abort mid-word
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("abort_count3", 32'(m_count), 32'h3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("abort_count", 32'(m_count), 32'h0);
    chk("abort_valid", 32'(m_valid), 32'h0);
    send_word(8'h5A, 1'b1);
    chk("abort_data",  32'(m_data),  32'h5A);
    chk("abort_wvalid", 32'(m_valid), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-word
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("areset_pre_count", 32'(m_count), 32'h5);
    @(negedge in_clock);
    in_enable = 1'b0;
    #2;
    in_reset = 1'b1;
    #1;
    chk("areset_data",  32'(m_data),  32'h0);
    chk("areset_count", 32'(m_count), 32'h0);
    chk("areset_valid", 32'(m_valid), 32'h0);
    chk("areset_ovr",   32'(m_ovr),   32'h0);
    @(negedge in_clock);
    in_reset = 1'b0;
    send_word(8'hC3, 1'b1);
    chk("areset_c3_data",  32'(m_data),  32'hC3);
    chk("areset_c3_valid", 32'(m_valid), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // LSB-first instance: bits 1,0,1,0,1,1,0,0 in arrival order
    lsb_bits = 8'b10101100;
    for (int i = 0; i < 8; i++) step(1'b1, lsb_bits[7-i], 1'b1, 1'b0);
    chk("lsb_data",  32'(l_data),  32'h35);
    chk("lsb_valid", 32'(l_valid), 32'h1);
    chk("lsb_msb_view", 32'(m_data), 32'hAC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
